// File: rtl/alu_pkg.sv
// Shared ALU opcode map and widths used by the arbiter, the alu and the bench.
package alu_pkg;
    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_TAG_W  = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd10;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request/response channel into the shared ALU.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int TAG_W  = ALU_TAG_W
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag
    );
endinterface

// File: rtl/alu.sv
// 32-bit combinational ALU; undefined opcodes yield result 0 (and hence zero=1).
module alu
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] entrada1,
    input  logic [ALU_DATA_W-1:0] entrada2,
    input  logic [ALU_OP_W-1:0]   alu_control,
    output logic [ALU_DATA_W-1:0] resultado,
    output logic                  zero
);
    logic [4:0] shamt;
    assign shamt = entrada2[4:0];

    always_comb begin
        resultado = '0;
        case (alu_control)
            ALU_ADD:  resultado = entrada1 + entrada2;
            ALU_SUB:  resultado = entrada1 - entrada2;
            ALU_AND:  resultado = entrada1 & entrada2;
            ALU_OR:   resultado = entrada1 | entrada2;
            ALU_XOR:  resultado = entrada1 ^ entrada2;
            ALU_NOR:  resultado = ~(entrada1 | entrada2);
            ALU_SLT:  resultado = {{(ALU_DATA_W-1){1'b0}}, $signed(entrada1) < $signed(entrada2)};
            ALU_SLTU: resultado = {{(ALU_DATA_W-1){1'b0}}, entrada1 < entrada2};
            ALU_SLL:  resultado = entrada1 << shamt;
            ALU_SRL:  resultado = entrada1 >> shamt;
            ALU_SRA:  resultado = $unsigned($signed(entrada1) >>> shamt);
            default:  resultado = '0;
        endcase
    end

    assign zero = (resultado == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU with a
// one-entry registered response slot per requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int TAG_W  = ALU_TAG_W
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  req0_if,
    alu_arbiter_if.slave  req1_if
);
    logic [1:0]             req_valid, rsp_ready, rsp_valid;
    logic [1:0]             can_acc, cand, win, req_ready;
    logic [1:0][DATA_W-1:0] req_a, req_b, rsp_result;
    logic [1:0][OP_W-1:0]   req_op;
    logic [1:0][TAG_W-1:0]  req_tag, rsp_tag;
    logic [1:0]             rsp_zero;
    logic                   prio_q;
    logic                   sel;
    logic [DATA_W-1:0]      alu_res;
    logic                   alu_zero;

    assign req_valid = {req1_if.req_valid, req0_if.req_valid};
    assign rsp_ready = {req1_if.rsp_ready, req0_if.rsp_ready};
    assign req_a     = {req1_if.req_a,     req0_if.req_a};
    assign req_b     = {req1_if.req_b,     req0_if.req_b};
    assign req_op    = {req1_if.req_op,    req0_if.req_op};
    assign req_tag   = {req1_if.req_tag,   req0_if.req_tag};

    // A candidate can win only if its slot is free now or drains this cycle.
    assign cand   = req_valid & can_acc;
    assign win[0] = cand[0] & (~prio_q | ~cand[1]);
    assign win[1] = cand[1] & ( prio_q | ~cand[0]);

    // Ready deliberately ignores the requester's own valid.
    assign req_ready[0] = can_acc[0] & ~(cand[1] &  prio_q);
    assign req_ready[1] = can_acc[1] & ~(cand[0] & ~prio_q);

    // Idle cycles steer the prio side's operands so the ALU never sees X.
    assign sel = win[1] | (~win[0] & prio_q);

    alu u_alu (
        .entrada1    (req_a[sel]),
        .entrada2    (req_b[sel]),
        .alu_control (req_op[sel]),
        .resultado   (alu_res),
        .zero        (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prio_q <= 1'b0;
        else if (win[0]) prio_q <= 1'b1;
        else if (win[1]) prio_q <= 1'b0;
    end

    for (genvar n = 0; n < 2; n++) begin : g_slot
        slot_state_e       state_q;
        logic [DATA_W-1:0] res_q;
        logic              zero_q;
        logic [TAG_W-1:0]  tag_q;

        assign can_acc[n]    = (state_q == SLOT_EMPTY) | rsp_ready[n];
        assign rsp_valid[n]  = (state_q == SLOT_FULL);
        assign rsp_result[n] = res_q;
        assign rsp_zero[n]   = zero_q;
        assign rsp_tag[n]    = tag_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= SLOT_EMPTY;
                res_q   <= '0;
                zero_q  <= 1'b0;
                tag_q   <= '0;
            end else begin
                if (win[n]) begin
                    res_q  <= alu_res;
                    zero_q <= alu_zero;
                    tag_q  <= req_tag[n];
                end
                case (state_q)
                    SLOT_EMPTY: if (win[n]) state_q <= SLOT_FULL;
                    SLOT_FULL:  if (!win[n] && rsp_ready[n]) state_q <= SLOT_EMPTY;
                    default:    state_q <= SLOT_EMPTY;
                endcase
            end
        end
    end

    assign req0_if.req_ready  = req_ready[0];
    assign req0_if.rsp_valid  = rsp_valid[0];
    assign req0_if.rsp_result = rsp_result[0];
    assign req0_if.rsp_zero   = rsp_zero[0];
    assign req0_if.rsp_tag    = rsp_tag[0];
    assign req1_if.req_ready  = req_ready[1];
    assign req1_if.rsp_valid  = rsp_valid[1];
    assign req1_if.rsp_result = rsp_result[1];
    assign req1_if.rsp_zero   = rsp_zero[1];
    assign req1_if.rsp_tag    = rsp_tag[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level model of the arbiter.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(32), .OP_W(4), .TAG_W(4)) p0();
    alu_arbiter_if #(.DATA_W(32), .OP_W(4), .TAG_W(4)) p1();

    alu_arbiter dut (.clk(clk), .rst_n(rst_n), .req0_if(p0), .req1_if(p1));

    int n_cmp = 0;
    int n_err = 0;

    // Model: what each consumer should currently see, and who wins a tie.
    bit          m_v[2];
    logic [31:0] m_r[2];
    bit          m_z[2];
    logic [3:0]  m_t[2];
    int          m_prio;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + ~b + 32'd1;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~a & ~b;
            ALU_SLT:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                return r;
            end
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_v[n] = 0; m_r[n] = '0; m_z[n] = 0; m_t[n] = '0;
        end
        m_prio = 0;
    endtask

    task automatic set_req(input int n, input bit v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        if (n == 0) begin
            p0.req_valid = v; p0.req_op = op; p0.req_a = a; p0.req_b = b; p0.req_tag = tag;
        end else begin
            p1.req_valid = v; p1.req_op = op; p1.req_a = a; p1.req_b = b; p1.req_tag = tag;
        end
    endtask

    task automatic set_rr(input bit r0, input bit r1);
        p0.rsp_ready = r0; p1.rsp_ready = r1;
    endtask

    task automatic rand_inputs();
        for (int n = 0; n < 2; n++)
            set_req(n, ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                    4'($urandom_range(0, 15)));
        set_rr(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
    endtask

    task automatic check_rsp();
        chk("rsp0_valid",  p0.rsp_valid,  m_v[0]);
        chk("rsp0_result", p0.rsp_result, m_r[0]);
        chk("rsp0_zero",   p0.rsp_zero,   m_z[0]);
        chk("rsp0_tag",    p0.rsp_tag,    m_t[0]);
        chk("rsp1_valid",  p1.rsp_valid,  m_v[1]);
        chk("rsp1_result", p1.rsp_result, m_r[1]);
        chk("rsp1_zero",   p1.rsp_zero,   m_z[1]);
        chk("rsp1_tag",    p1.rsp_tag,    m_t[1]);
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic run_cycle();
        bit          v[2], rr[2], free[2], elig[2], rdy[2];
        logic [31:0] a[2], b[2];
        logic [3:0]  op[2], tg[2];
        int          g;
        #1;
        v[0] = p0.req_valid;  v[1] = p1.req_valid;
        rr[0] = p0.rsp_ready; rr[1] = p1.rsp_ready;
        a[0] = p0.req_a;   a[1] = p1.req_a;   b[0] = p0.req_b;     b[1] = p1.req_b;
        op[0] = p0.req_op; op[1] = p1.req_op; tg[0] = p0.req_tag;  tg[1] = p1.req_tag;
        for (int n = 0; n < 2; n++) begin
            free[n] = !m_v[n] || rr[n];
            elig[n] = v[n] && free[n];
        end
        for (int n = 0; n < 2; n++)
            rdy[n] = free[n] && !(elig[1-n] && m_prio == 1-n);
        chk("req0_ready", p0.req_ready, rdy[0]);
        chk("req1_ready", p1.req_ready, rdy[1]);
        g = -1;
        if (elig[0] && elig[1]) g = m_prio;
        else if (elig[0])       g = 0;
        else if (elig[1])       g = 1;
        for (int n = 0; n < 2; n++)
            if (m_v[n] && rr[n]) m_v[n] = 0;
        if (g >= 0) begin
            m_v[g] = 1;
            m_r[g] = ref_alu(op[g], a[g], b[g]);
            m_z[g] = (m_r[g] == 32'd0);
            m_t[g] = tg[g];
            m_prio = 1 - g;
        end
        @(posedge clk);
        #1;
        check_rsp();
        @(negedge clk);
    endtask

    task automatic idle_drain();
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        set_req(1, 0, ALU_ADD, 0, 0, 0);
        set_rr(1, 1);
        run_cycle();
    endtask

    task automatic give_prio0();
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        set_req(1, 1, ALU_XOR, 32'h1234, 32'h1, 4'h9);
        set_rr(1, 1);
        run_cycle();
        idle_drain();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        rand_inputs();
        #1;
        chk("rst_rsp0_valid", p0.rsp_valid, 0);
        chk("rst_rsp1_valid", p1.rsp_valid, 0);
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            rand_inputs();
            check_rsp();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        set_req(1, 0, ALU_ADD, 0, 0, 0);
        set_rr(0, 0);
        model_reset();

        // 1: reset with random inputs, then req0 wins the first contest
        do_reset(3);
        set_req(0, 1, ALU_ADD, 32'd1, 32'd2, 4'h1);
        set_req(1, 1, ALU_ADD, 32'd3, 32'd4, 4'h2);
        set_rr(1, 1);
        #1;
        chk("t1_rdy0", p0.req_ready, 1);
        chk("t1_rdy1", p1.req_ready, 0);
        run_cycle();
        chk("t1_rsp0_v", p0.rsp_valid, 1);
        chk("t1_rsp1_v", p1.rsp_valid, 0);
        idle_drain();
        idle_drain();
        give_prio0();

        // 2: single ADD on req0
        set_req(0, 1, ALU_ADD, 32'd5, 32'd7, 4'd3);
        set_rr(1, 1);
        run_cycle();
        chk("t2_res",  p0.rsp_result, 32'd12);
        chk("t2_zero", p0.rsp_zero,   0);
        chk("t2_tag",  p0.rsp_tag,    4'd3);
        chk("t2_v1",   p1.rsp_valid,  0);
        idle_drain();
        give_prio0();

        // 3: contest SUB vs signed SLT
        set_req(0, 1, ALU_SUB, 32'd3, 32'd3, 4'h4);
        set_req(1, 1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'h5);
        set_rr(1, 1);
        run_cycle();
        chk("t3_res0",  p0.rsp_result, 32'd0);
        chk("t3_zero0", p0.rsp_zero,   1);
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        run_cycle();
        chk("t3_res1", p1.rsp_result, 32'd1);
        chk("t3_v1",   p1.rsp_valid,  1);
        set_req(0, 1, ALU_AND, 32'hFF, 32'h0F, 4'h6);
        set_req(1, 1, ALU_OR,  32'h1,  32'h2,  4'h7);
        #1;
        chk("t3_prio_rdy0", p0.req_ready, 1);
        chk("t3_prio_rdy1", p1.req_ready, 0);
        run_cycle();
        idle_drain();
        idle_drain();
        give_prio0();

        // 4: slot0 held full, req1 wins despite prio=0
        set_req(0, 1, ALU_ADD, 32'd100, 32'd23, 4'hA);
        set_rr(0, 1);
        run_cycle();
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        set_req(1, 1, ALU_SUB, 32'd9, 32'd4, 4'hB);
        run_cycle();
        set_req(0, 1, ALU_ADD, 32'd1, 32'd1, 4'hC);
        set_req(1, 1, ALU_SRA, 32'h8000_0000, 32'd4, 4'hD);
        #1;
        chk("t4_rdy0", p0.req_ready, 0);
        chk("t4_rdy1", p1.req_ready, 1);
        run_cycle();
        chk("t4_res1", p1.rsp_result, 32'hF800_0000);
        set_req(1, 0, ALU_ADD, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            chk("t4_hold", p0.rsp_result, 32'd123);
        end

        // 5: drain and refill slot0 in the same cycle
        set_req(0, 1, ALU_OR, 32'hF0, 32'h0F, 4'hE);
        set_rr(1, 1);
        run_cycle();
        chk("t5_v0",  p0.rsp_valid,  1);
        chk("t5_res", p0.rsp_result, 32'hFF);
        idle_drain();

        // 6: asynchronous reset while slot1 is full
        set_req(1, 1, ALU_ADD, 32'd8, 32'd8, 4'h3);
        set_rr(1, 0);
        run_cycle();
        chk("t6_pre_v1", p1.rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_v1", p1.rsp_valid, 0);
        model_reset();
        set_req(0, 0, ALU_ADD, 0, 0, 0);
        set_req(1, 0, ALU_ADD, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle();
        set_req(0, 1, ALU_XOR, 32'h5, 32'h5, 4'h1);
        set_req(1, 1, ALU_XOR, 32'h5, 32'h4, 4'h2);
        run_cycle();
        chk("t6_prio0", p0.rsp_valid, 1);

        // random traffic, with illegal opcodes included
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
